apb_controller: RTL and testbench
=================================

Name: apb_controller

Overview:
AHB-to-APB bridge control FSM. It sits directly upstream of apb_interface.
- Accepts one AHB transfer from the AHB slave/decode stage.
- Sequences the APB SETUP and ACCESS phases on p_write, p_enable, p_selx, paddr and pwdata.
- Returns read data and hready_out to the AHB side.
- Handles a single outstanding transfer; hready_out stalls the master while busy.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
SEL_W, 3, one-hot peripheral select width

Ports:
hclk  in  1  single clock; all state changes on rising edge
hreset  in  1  synchronous, active-high reset
valid  in  1  AHB NONSEQ/SEQ transfer addressed to bridge
hwrite  in  1  AHB direction, address phase (1 = write)
haddr  in  ADDR_W  AHB address, address phase
hwdata  in  DATA_W  AHB write data, data phase (cycle after address)
tempselx  in  SEL_W  decoded one-hot peripheral select, address phase
pr_data  in  DATA_W  read data from apb_interface
p_write  out  1  APB PWRITE
p_enable  out  1  APB PENABLE
p_selx  out  SEL_W  APB PSELx
paddr  out  ADDR_W  APB PADDR
pwdata  out  DATA_W  APB PWDATA
hready_out  out  1  bridge ready to AHB
hr_data  out  DATA_W  read data to AHB

Behaviour:
- Clock and reset: one clock (hclk); reset is synchronous and active-high (hreset).
- Reset values:
  - FSM in ST_IDLE; hready_out=1.
  - p_write, p_enable, p_selx, paddr, pwdata, hr_data all 0.
  - Internal regs addr_q, sel_q, write_q, wdata_q all 0.
- Output timing: all outputs are registered; there are no combinational paths from inputs to outputs.
- Accept condition: valid & hready_out & (tempselx != 0).
  - On accept, capture haddr→addr_q, tempselx→sel_q, hwrite→write_q.
  - valid with tempselx==0 is ignored; FSM stays in ST_IDLE.
- States and transitions:
  - ST_IDLE: on accept, go to ST_WWAIT if hwrite, else ST_SETUP.
  - ST_WWAIT: capture hwdata→wdata_q; go to ST_SETUP.
  - ST_SETUP: one cycle; go to ST_ACCESS.
  - ST_ACCESS: one cycle. If write_q=0, capture pr_data→hr_data. Go to ST_IDLE.
- Outputs per state (registered, valid during the state):
  - ST_IDLE, ST_WWAIT: p_selx=0, p_enable=0. paddr, pwdata and p_write hold their last values.
  - ST_SETUP: p_selx=sel_q, paddr=addr_q, p_write=write_q, pwdata=wdata_q (writes only; reads leave pwdata unchanged), p_enable=0.
  - ST_ACCESS: same as ST_SETUP but p_enable=1.
  - hready_out=1 only in ST_IDLE; 0 in ST_WWAIT, ST_SETUP and ST_ACCESS.
- Latency, counted from the accept edge:
  - Read: SETUP at +1, ACCESS at +2, hready_out=1 with hr_data valid at +3.
  - Write: WWAIT at +1, SETUP at +2, ACCESS at +3, hready_out=1 at +4.
- hr_data holds its value until the next read ACCESS. Writes do not change it.
- Back-to-back transfers: a new transfer can be accepted in the first ST_IDLE cycle after ACCESS. There is no pipelining.
- valid while busy: ignored. The AHB master holds its address phase because hready_out=0.
- Reset mid-transfer: at the next edge return to ST_IDLE with reset values. Any in-flight APB transfer is abandoned (p_selx and p_enable drop to 0).
- Widths: no arithmetic. Selects are passed through unchanged; one-hotness is not checked.

Decomposition:
- Shared package (bridge_pkg):
  - State enum: ST_IDLE, ST_WWAIT, ST_SETUP, ST_ACCESS.
  - Defaults for ADDR_W, DATA_W, SEL_W.
  - SEL_NONE constant (all zeros).
- Single module: no sub-module. The capture registers and the FSM are both small.

Test Plan:
- Reset: hold hreset=1 for 2 cycles mid-write (state ST_SETUP) → next edge: p_selx=0, p_enable=0, hready_out=1, hr_data=0, state ST_IDLE.
- Read: valid=1, hwrite=0, haddr=32'h8000_0010, tempselx=3'b001, pr_data=32'h0000_00A5 → +1: p_selx=001, p_enable=0, paddr=8000_0010, p_write=0. +2: p_enable=1. +3: hready_out=1, hr_data=32'h0000_00A5.
- Write: valid=1, hwrite=1, haddr=32'h8400_0004, tempselx=3'b010; next cycle hwdata=32'hDEAD_BEEF → +2: p_selx=010, p_write=1, pwdata=DEAD_BEEF, p_enable=0. +3: p_enable=1. +4: hready_out=1; hr_data unchanged.
- Decode miss: valid=1, tempselx=3'b000 → stays ST_IDLE, hready_out=1, p_selx=0 for 3 cycles.
- Busy stall: a second valid read (tempselx=3'b100) held during the first read → second transfer accepted only at +3. Its SETUP (p_selx=100) appears at +4; paddr shows the second address.
- Read after write: write DEAD_BEEF then read with pr_data=32'h12 → hr_data changes only at the read completion, to 32'h0000_0012.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and defaults for the AHB-to-APB bridge control path.
// Holds the FSM state encoding, default bus widths and the empty-select constant.
// Imported by apb_controller; contains no logic.
package bridge_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int SEL_W_DEF  = 3;

  // No peripheral selected; also marks an AHB decode miss on tempselx.
  localparam logic [SEL_W_DEF-1:0] SEL_NONE = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WWAIT  = 2'd1,
    ST_SETUP  = 2'd2,
    ST_ACCESS = 2'd3
  } state_e;

endpackage

// File: rtl/apb_controller.sv
// AHB-to-APB bridge control FSM: captures one AHB transfer and drives APB SETUP/ACCESS.
// Latency from accept edge: read 3 cycles to hready_out, write 4 (extra cycle for hwdata).
// Backpressure: hready_out low while a transfer is in flight; valid is ignored until idle.
module apb_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [SEL_W-1:0]  tempselx,
  input  logic [DATA_W-1:0] pr_data,
  output logic              p_write,
  output logic              p_enable,
  output logic [SEL_W-1:0]  p_selx,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hready_out,
  output logic [DATA_W-1:0] hr_data
);

  localparam logic [SEL_W-1:0] NO_SEL = SEL_W'(SEL_NONE);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                p_write_q, p_write_d;
  logic                p_enable_q, p_enable_d;
  logic [SEL_W-1:0]    p_selx_q, p_selx_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                hready_out_q, hready_out_d;
  logic [DATA_W-1:0]   hr_data_q, hr_data_d;

  logic                accept;

  // A decode miss (no select bit) never starts a transfer.
  assign accept = valid & hready_out_q & (tempselx != NO_SEL);

  // Next state and capture of the AHB address/data phases.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = haddr;
          sel_d   = tempselx;
          write_d = hwrite;
          state_d = hwrite ? ST_WWAIT : ST_SETUP;
        end
      end
      ST_WWAIT: begin
        // AHB write data arrives one cycle after its address phase.
        wdata_d = hwdata;
        state_d = ST_SETUP;
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Registered APB/AHB outputs computed from the state being entered, so no input reaches an output combinationally.
  always_comb begin
    p_selx_d     = NO_SEL;
    p_enable_d   = 1'b0;
    paddr_d      = paddr_q;
    p_write_d    = p_write_q;
    pwdata_d     = pwdata_q;
    hready_out_d = (state_d == ST_IDLE);
    hr_data_d    = hr_data_q;
    if ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) begin
      p_selx_d  = sel_d;
      paddr_d   = addr_d;
      p_write_d = write_d;
      if (write_d) begin
        pwdata_d = wdata_d;
      end
    end
    if (state_d == ST_ACCESS) begin
      p_enable_d = 1'b1;
    end
    // Peripheral read data is valid during ACCESS; it is held until the next read completes.
    if ((state_q == ST_ACCESS) && !write_q) begin
      hr_data_d = pr_data;
    end
  end

  // State, capture and output registers with synchronous reset.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      sel_q        <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      p_write_q    <= 1'b0;
      p_enable_q   <= 1'b0;
      p_selx_q     <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      hready_out_q <= 1'b1;
      hr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      p_write_q    <= p_write_d;
      p_enable_q   <= p_enable_d;
      p_selx_q     <= p_selx_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      hready_out_q <= hready_out_d;
      hr_data_q    <= hr_data_d;
    end
  end

  assign p_write    = p_write_q;
  assign p_enable   = p_enable_q;
  assign p_selx     = p_selx_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign hready_out = hready_out_q;
  assign hr_data    = hr_data_q;

endmodule

// File: tb/tb_apb_controller.sv
// Bench for apb_controller: transaction-level model with per-cycle compare plus directed literal checks.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Model tracks each transfer by its age in cycles since acceptance.
module tb_apb_controller;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        valid;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  tempselx;
  logic [31:0] pr_data;
  logic        p_write;
  logic        p_enable;
  logic [2:0]  p_selx;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        hready_out;
  logic [31:0] hr_data;

  int tests = 0;
  int fails = 0;

  always #5 hclk = ~hclk;

  apb_controller dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .valid      (valid),
    .hwrite     (hwrite),
    .haddr      (haddr),
    .hwdata     (hwdata),
    .tempselx   (tempselx),
    .pr_data    (pr_data),
    .p_write    (p_write),
    .p_enable   (p_enable),
    .p_selx     (p_selx),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .hready_out (hready_out),
    .hr_data    (hr_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic        m_ok = 1'b0;
  logic        m_busy;
  int          m_age;
  logic        m_wr;
  logic [31:0] m_addr;
  logic [2:0]  m_sel;
  logic [31:0] m_wdata;
  logic [31:0] e_paddr, e_pwdata, e_hrdata;
  logic        e_pwrite;

  function automatic int setup_age(input logic wr);
    return wr ? 2 : 1;
  endfunction

  initial begin
    forever begin
      @(posedge hclk);
      if (hreset) begin
        m_busy = 0; m_age = 0; m_wr = 0; m_addr = 0; m_sel = 0; m_wdata = 0;
        e_paddr = 0; e_pwdata = 0; e_hrdata = 0; e_pwrite = 0;
        m_ok = 1'b1;
      end else if (m_ok) begin
        if (m_busy) begin
          m_age++;
          if (m_wr && m_age == 2) m_wdata = hwdata;
          if (!m_wr && m_age == 3) e_hrdata = pr_data;
          if (m_age == (m_wr ? 4 : 3)) m_busy = 0;
        end else if (valid && tempselx != 3'b000) begin
          m_busy = 1; m_age = 1;
          m_wr = hwrite; m_addr = haddr; m_sel = tempselx;
        end
        if (m_busy && m_age == setup_age(m_wr)) begin
          e_paddr  = m_addr;
          e_pwrite = m_wr;
          if (m_wr) e_pwdata = m_wdata;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge hclk);
      if (m_ok) begin
        logic in_setup, in_access;
        in_setup  = m_busy && (m_age == setup_age(m_wr));
        in_access = m_busy && (m_age == setup_age(m_wr) + 1);
        chk("hready_out", {31'b0, hready_out}, {31'b0, !m_busy});
        chk("p_selx", {29'b0, p_selx}, (in_setup || in_access) ? {29'b0, m_sel} : 32'h0);
        chk("p_enable", {31'b0, p_enable}, {31'b0, in_access});
        chk("paddr", paddr, e_paddr);
        chk("p_write", {31'b0, p_write}, {31'b0, e_pwrite});
        chk("pwdata", pwdata, e_pwdata);
        chk("hr_data", hr_data, e_hrdata);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; hwrite = 0; haddr = 0; hwdata = 0; tempselx = 3'b000;
  endtask

  initial begin
    hreset = 1; pr_data = 0;
    idle_inputs();
    tick(2);
    hreset = 0;
    @(negedge hclk);
    chk("rst_hready_lit", {31'b0, hready_out}, 32'h1);
    chk("rst_hrdata_lit", hr_data, 32'h0);
    chk("rst_pselx_lit", {29'b0, p_selx}, 32'h0);
    tick(1);

    // Read
    valid = 1; hwrite = 0; haddr = 32'h8000_0010; tempselx = 3'b001; pr_data = 32'h0000_00A5;
    tick(1); idle_inputs();
    @(negedge hclk);
    chk("rd_p1_pselx", {29'b0, p_selx}, 32'h1);
    chk("rd_p1_paddr", paddr, 32'h8000_0010);
    chk("rd_p1_penable", {31'b0, p_enable}, 32'h0);
    chk("rd_p1_pwrite", {31'b0, p_write}, 32'h0);
    tick(1); @(negedge hclk);
    chk("rd_p2_penable", {31'b0, p_enable}, 32'h1);
    tick(1); @(negedge hclk);
    chk("rd_p3_hready", {31'b0, hready_out}, 32'h1);
    chk("rd_p3_hrdata", hr_data, 32'h0000_00A5);
    chk("model_rd_hrdata", e_hrdata, 32'h0000_00A5);
    tick(1);

    // Write
    valid = 1; hwrite = 1; haddr = 32'h8400_0004; tempselx = 3'b010;
    tick(1); idle_inputs(); hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    chk("wr_p1_hready", {31'b0, hready_out}, 32'h0);
    tick(1); hwdata = 32'h0;
    @(negedge hclk);
    chk("wr_p2_pselx", {29'b0, p_selx}, 32'h2);
    chk("wr_p2_pwrite", {31'b0, p_write}, 32'h1);
    chk("wr_p2_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr_p2_penable", {31'b0, p_enable}, 32'h0);
    chk("model_wr_pwdata", e_pwdata, 32'hDEAD_BEEF);
    tick(1); @(negedge hclk);
    chk("wr_p3_penable", {31'b0, p_enable}, 32'h1);
    tick(1); @(negedge hclk);
    chk("wr_p4_hready", {31'b0, hready_out}, 32'h1);
    chk("wr_p4_hrdata", hr_data, 32'h0000_00A5);
    tick(1);

    // Decode miss
    valid = 1; hwrite = 0; haddr = 32'h9000_0000; tempselx = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick(1); @(negedge hclk);
      chk("miss_hready", {31'b0, hready_out}, 32'h1);
      chk("miss_pselx", {29'b0, p_selx}, 32'h0);
    end
    tick(0); idle_inputs();
    tick(1);

    // Busy stall: second read held while first is in flight
    valid = 1; hwrite = 0; haddr = 32'h0000_0010; tempselx = 3'b001; pr_data = 32'h33;
    tick(1);
    haddr = 32'h0000_0020; tempselx = 3'b100;
    tick(1); @(negedge hclk);
    chk("stall_p2_paddr", paddr, 32'h0000_0010);
    chk("stall_p2_penable", {31'b0, p_enable}, 32'h1);
    tick(1); @(negedge hclk);
    chk("stall_p3_hready", {31'b0, hready_out}, 32'h1);
    chk("stall_p3_hrdata", hr_data, 32'h33);
    tick(1); idle_inputs(); pr_data = 32'h44;
    @(negedge hclk);
    chk("stall_p4_pselx", {29'b0, p_selx}, 32'h4);
    chk("stall_p4_paddr", paddr, 32'h0000_0020);
    tick(3); @(negedge hclk);
    chk("stall_rd2_hrdata", hr_data, 32'h44);

    // Read after write
    pr_data = 32'h12;
    valid = 1; hwrite = 1; haddr = 32'h8400_0008; tempselx = 3'b010;
    tick(1); idle_inputs(); hwdata = 32'hDEAD_BEEF;
    tick(1); hwdata = 0;
    tick(2); @(negedge hclk);
    chk("raw_wr_hrdata", hr_data, 32'h44);
    valid = 1; hwrite = 0; haddr = 32'h8000_0014; tempselx = 3'b001;
    tick(1); idle_inputs();
    tick(1); @(negedge hclk);
    chk("raw_access_hrdata", hr_data, 32'h44);
    tick(1); @(negedge hclk);
    chk("raw_rd_hrdata", hr_data, 32'h0000_0012);
    tick(1);

    // Reset in the middle of a write, during SETUP
    valid = 1; hwrite = 1; haddr = 32'h8400_000C; tempselx = 3'b010;
    tick(1); idle_inputs(); hwdata = 32'hCAFE_F00D;
    tick(1); hwdata = 0;
    @(negedge hclk);
    chk("mid_setup_pselx", {29'b0, p_selx}, 32'h2);
    hreset = 1;
    tick(1); @(negedge hclk);
    chk("mid_rst_pselx", {29'b0, p_selx}, 32'h0);
    chk("mid_rst_penable", {31'b0, p_enable}, 32'h0);
    chk("mid_rst_hready", {31'b0, hready_out}, 32'h1);
    chk("mid_rst_hrdata", hr_data, 32'h0);
    tick(1); hreset = 0;
    tick(3); @(negedge hclk);
    chk("post_rst_hready", {31'b0, hready_out}, 32'h1);
    chk("post_rst_paddr", paddr, 32'h0);

    tick(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
